// File: rtl/ringosc_bank_ctrl.sv
// Ring-oscillator bank controller: round-robin start/trim/clkmux drive and
// gated edge-count frequency measurement, results on a valid/ready stream.
module ringosc_bank_ctrl #(
    parameter int NUM_RINGS     = 2,
    parameter int TRIM_W        = 28,
    parameter int CLKMUX_W      = 3,
    parameter int GATE_W        = 16,
    parameter int CNT_W         = 20,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          cfg_enable,
    input  logic [NUM_RINGS*TRIM_W-1:0]   cfg_trim,
    input  logic [NUM_RINGS*CLKMUX_W-1:0] cfg_clkmux,
    input  logic [GATE_W-1:0]             cfg_gate,
    input  logic [NUM_RINGS-1:0]          ring_clk_i,
    output logic [NUM_RINGS-1:0]          ring_start_o,
    output logic [NUM_RINGS*TRIM_W-1:0]   ring_trim_o,
    output logic [NUM_RINGS*CLKMUX_W-1:0] ring_clkmux_o,
    output logic                          meas_valid_o,
    input  logic                          meas_ready_i,
    output logic [2:0]                    meas_chan_o,
    output logic [CNT_W-1:0]              meas_count_o,
    output logic                          meas_ovf_o,
    output logic                          busy_o
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_REPORT
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [2:0]                    r_ch;
    logic [2:0]                    w_ch_inc;
    logic [2:0]                    w_ch_load;
    logic [SW-1:0]                 r_settle;
    logic [GATE_W-1:0]             r_gate;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_ovf;
    logic [NUM_RINGS-1:0]          r_sync1;
    logic [NUM_RINGS-1:0]          r_sync2;
    logic [NUM_RINGS-1:0]          r_prev;
    logic [NUM_RINGS-1:0]          w_edge;
    logic [NUM_RINGS-1:0]          w_onehot;
    logic                          w_hit;
    logic                          w_enter_settle;
    logic [NUM_RINGS*TRIM_W-1:0]   r_trim;
    logic [NUM_RINGS*CLKMUX_W-1:0] r_mux;

    assign w_edge         = r_sync2 & ~r_prev;
    assign w_ch_inc       = (r_ch == 3'(NUM_RINGS - 1)) ? 3'd0 : r_ch + 3'd1;
    assign w_ch_load      = (r_state == S_REPORT) ? w_ch_inc : r_ch;
    assign w_enter_settle = (r_state != S_SETTLE) && (w_next == S_SETTLE);
    assign ring_trim_o    = r_trim;
    assign ring_clkmux_o  = r_mux;

    // Decode the active channel into a one-hot enable and its edge strobe
    always_comb begin
        w_onehot = '0;
        w_hit    = 1'b0;
        for (int k = 0; k < NUM_RINGS; k++) begin
            if (r_ch == 3'(k)) begin
                w_onehot[k] = 1'b1;
                w_hit       = w_edge[k];
            end
        end
    end

    // Next-state and stream/enable outputs
    always_comb begin
        w_next       = r_state;
        ring_start_o = '0;
        meas_valid_o = 1'b0;
        meas_chan_o  = 3'd0;
        meas_count_o = '0;
        meas_ovf_o   = 1'b0;
        busy_o       = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (cfg_enable) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                ring_start_o = w_onehot;
                if (r_settle == '0) w_next = S_GATE;
            end
            S_GATE: begin
                ring_start_o = w_onehot;
                if (r_gate == GATE_W'(1)) w_next = S_REPORT;
            end
            S_REPORT: begin
                meas_valid_o = 1'b1;
                meas_chan_o  = r_ch;
                meas_count_o = r_cnt;
                meas_ovf_o   = r_ovf;
                if (meas_ready_i) begin
                    w_next = cfg_enable ? S_SETTLE : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Two-flop synchroniser plus previous-value register for edge detect
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= ring_clk_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Channel pointer, settle timer, gate window and saturating edge count
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ch     <= 3'd0;
            r_settle <= '0;
            r_gate   <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == S_REPORT && meas_ready_i) r_ch <= w_ch_inc;
            if (w_enter_settle) begin
                r_settle <= SW'(SETTLE_CYCLES - 1);
            end else if (r_state == S_SETTLE && r_settle != '0) begin
                r_settle <= r_settle - SW'(1);
            end
            if (r_state == S_SETTLE && w_next == S_GATE) begin
                r_gate <= (cfg_gate == '0) ? GATE_W'(1) : cfg_gate;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
            end else if (r_state == S_GATE) begin
                r_gate <= r_gate - GATE_W'(1);
                if (w_hit) begin
                    if (&r_cnt) r_ovf <= 1'b1;
                    else        r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Latch the selected channel's trim/clkmux on entry to SETTLE
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_trim <= '0;
            r_mux  <= '0;
        end else if (w_enter_settle) begin
            for (int k = 0; k < NUM_RINGS; k++) begin
                if (w_ch_load == 3'(k)) begin
                    r_trim[k*TRIM_W +: TRIM_W] <= cfg_trim[k*TRIM_W +: TRIM_W];
                    r_mux[k*CLKMUX_W +: CLKMUX_W] <=
                        cfg_clkmux[k*CLKMUX_W +: CLKMUX_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_ringosc_bank_ctrl.sv
// Directed bench for ringosc_bank_ctrl: default-size instance for counting,
// scan order and reset; a 4-bit-count instance for saturation/backpressure.
module tb_ringosc_bank_ctrl;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        rdy  = 1'b1;
    logic        en2  = 1'b0;
    logic        rdy2 = 1'b1;
    logic [55:0] trim = {28'hABCDEF1, 28'h1234567};
    logic [5:0]  mux  = {3'd5, 3'd2};
    logic [15:0] gate  = 16'd800;
    logic [15:0] gate2 = 16'd200;
    logic [1:0]  rclk = 2'b00;

    logic [1:0]  s0, s2;
    logic [55:0] t0, t2;
    logic [5:0]  m0, m2;
    logic        v0, v2, o0, o2, b0, b2;
    logic [2:0]  ch0, ch2;
    logic [19:0] c0;
    logic [3:0]  c2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ringosc_bank_ctrl u_dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cfg_enable    (en),
        .cfg_trim      (trim),
        .cfg_clkmux    (mux),
        .cfg_gate      (gate),
        .ring_clk_i    (rclk),
        .ring_start_o  (s0),
        .ring_trim_o   (t0),
        .ring_clkmux_o (m0),
        .meas_valid_o  (v0),
        .meas_ready_i  (rdy),
        .meas_chan_o   (ch0),
        .meas_count_o  (c0),
        .meas_ovf_o    (o0),
        .busy_o        (b0)
    );

    ringosc_bank_ctrl #(.CNT_W(4)) u_sat (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cfg_enable    (en2),
        .cfg_trim      (trim),
        .cfg_clkmux    (mux),
        .cfg_gate      (gate2),
        .ring_clk_i    ({rclk[1], rclk[1]}),
        .ring_start_o  (s2),
        .ring_trim_o   (t2),
        .ring_clkmux_o (m2),
        .meas_valid_o  (v2),
        .meas_ready_i  (rdy2),
        .meas_chan_o   (ch2),
        .meas_count_o  (c2),
        .meas_ovf_o    (o2),
        .busy_o        (b2)
    );

    always #5 clk = ~clk;

    // ring0 period 8 wb clocks, ring1 period 4 wb clocks
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc % 4 == 0) rclk[0] = ~rclk[0];
        if (cyc % 2 == 0) rclk[1] = ~rclk[1];
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for one result on u_dut and check channel, count, ovf, latency
    task automatic meas(input string tag, input logic [2:0] expch,
                        input int expcnt, input int explat);
        int   lat = 0;
        int   bad = 0;
        logic got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (v0) begin
                got = 1'b1;
            end else begin
                if (b0) lat++;
                if (s0 !== (b0 ? 2'(1 << expch) : 2'b00)) bad++;
            end
        end
        check({tag, "_done"}, 64'(got), 64'd1);
        check({tag, "_start"}, 64'(bad), 64'd0);
        check({tag, "_rep_start"}, 64'(s0), 64'd0);
        check({tag, "_chan"}, 64'(ch0), 64'(expch));
        check({tag, "_ovf"}, 64'(o0), 64'd0);
        check({tag, "_lat"}, 64'(lat), 64'(explat));
        if (expcnt >= 0) check({tag, "_cnt"}, 64'(c0), 64'(expcnt));
    endtask

    initial begin
        logic [63:0] acc;
        logic [63:0] snap;
        int          lat2;
        int          bad2;
        logic        got2;

        // reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = acc | 64'({s0, t0, v0, ch0, o0, b0}) | 64'(m0) | 64'(c0);
            acc = acc | 64'({s2, t2, v2, ch2, o2, b2}) | 64'(m2) | 64'(c2);
        end
        check("idle_outputs", acc, 64'd0);

        // basic counts and trim latching
        en = 1'b1;
        meas("m1", 3'd0, 100, 816);
        check("m1_trim", 64'(t0), 64'({28'h0, 28'h1234567}));
        check("m1_mux", 64'(m0), 64'h02);
        meas("m2", 3'd1, 200, 816);
        check("m2_trim", 64'(t0), 64'({28'hABCDEF1, 28'h1234567}));
        check("m2_mux", 64'(m0), 64'h2A);
        meas("m3", 3'd0, 100, 816);
        meas("m4", 3'd1, 200, 816);

        // drop enable and change gate mid-measurement
        repeat (30) @(negedge clk);
        en   = 1'b0;
        gate = 16'd50;
        meas("m5", 3'd0, 100, 786);
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = acc | 64'({s0, v0, b0});
        end
        check("drop_idle", acc, 64'd0);

        // zero gate samples exactly one cycle; pointer was retained
        gate = 16'd0;
        en   = 1'b1;
        meas("m6", 3'd1, -1, 17);
        gate = 16'd800;
        meas("m7", 3'd0, 100, 816);

        // reset during GATE of channel 1
        repeat (100) @(negedge clk);
        check("pre_rst_start", 64'(s0), 64'h2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_start", 64'(s0), 64'd0);
        check("rst_valid", 64'(v0), 64'd0);
        check("rst_busy", 64'(b0), 64'd0);
        check("rst_trim", 64'(t0), 64'd0);
        rst = 1'b0;
        meas("m8", 3'd0, 100, 816);
        en = 1'b0;

        // saturation with backpressure on the 4-bit instance
        rdy2 = 1'b0;
        en2  = 1'b1;
        lat2 = 0;
        got2 = 1'b0;
        for (int i = 0; i < 2000 && !got2; i++) begin
            @(negedge clk);
            if (v2) got2 = 1'b1;
            else if (b2) lat2++;
        end
        check("sat_done", 64'(got2), 64'd1);
        check("sat_lat", 64'(lat2), 64'd216);
        check("sat_chan", 64'(ch2), 64'd0);
        check("sat_cnt", 64'(c2), 64'd15);
        check("sat_ovf", 64'(o2), 64'd1);
        snap = 64'({ch2, c2, o2, v2, s2, b2, t2});
        bad2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (64'({ch2, c2, o2, v2, s2, b2, t2}) !== snap) bad2++;
        end
        check("sat_stable", 64'(bad2), 64'd0);
        rdy2 = 1'b1;
        en2  = 1'b0;
        @(negedge clk);
        check("sat_xfer_valid", 64'(v2), 64'd0);
        check("sat_xfer_busy", 64'(b2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
